// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package mod_updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Enable-gated prescaler: emits one tick per PRESCALE enabled clocks.
module tick_prescaler
  import mod_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = en && (pre_cnt == LAST);

  // en=0 freezes the phase rather than clearing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre_cnt <= '0;
    else if (clr)
      pre_cnt <= '0;
    else if (en)
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, prescaler, wrap/saturate and tc pulse.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS %0d outside 2..2**%0d", MODULUS, WIDTH);
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE %0d must be >= 1", PRESCALE);
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("mod_updown_counter: SATURATE %0d must be 0 or 1", SATURATE);
  end

  logic             tick;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  if (PRESCALE > 1) begin : g_pre
    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (tick)
    );
  end else begin : g_nopre
    assign tick = en;
  end

  assign at_max = (q == MAXV);
  assign at_min = (q == '0);

  // Load wins over a coincident tick; values beyond the range clamp to the top
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (tick) begin
      if (up == DIR_UP) begin
        if (at_max) begin
          tc_nxt = 1'b1;
          q_nxt  = (SATURATE == MODE_SAT) ? q : '0;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          tc_nxt = 1'b1;
          q_nxt  = (SATURATE == MODE_SAT) ? q : MAXV;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: wrap, saturate and prescaled counters driven from shared inputs.
module tb_mod_updown_counter;
  import mod_updown_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = DIR_UP;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       mx0, mx1, mx2, mn0, mn1, mn2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) d_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q0), .tc(tc0), .at_max(mx0), .at_min(mn0));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) d_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q1), .tc(tc1), .at_max(mx1), .at_min(mn1));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) d_pre (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q2), .tc(tc2), .at_max(mx2), .at_min(mn2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    up   = DIR_UP;
    cyc();
    rst  = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_q", q0, 0);
    chk("rst_tc", tc0, 0);
    chk("rst_atmin", mn0, 1);
    cyc();
    rst = 1'b0;

    // Test 1: count up through the wrap
    en = 1'b1; up = DIR_UP;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk($sformatf("t1_q%0d", i), q0, i % 10);
      chk($sformatf("t1_tc%0d", i), tc0, (i == 10) ? 1 : 0);
      chk($sformatf("t1_max%0d", i), mx0, (i == 9) ? 1 : 0);
    end

    // Test 2: load 0 then count down through the lower bound
    load = 1'b1; load_val = 4'd0;
    cyc();
    chk("t2_load_q", q0, 0);
    chk("t2_load_tc", tc0, 0);
    load = 1'b0; up = DIR_DOWN;
    cyc();
    chk("t2_q9", q0, 9);
    chk("t2_tc9", tc0, 1);
    cyc();
    chk("t2_q8", q0, 8);
    chk("t2_tc8", tc0, 0);
    cyc();
    chk("t2_q7", q0, 7);
    chk("t2_tc7", tc0, 0);

    // Test 3: saturate at the top
    do_reset();
    load = 1'b1; load_val = 4'd8;
    cyc();
    chk("t3_load", q1, 8);
    load = 1'b0; en = 1'b1; up = DIR_UP;
    cyc();
    chk("t3_q_a", q1, 9);
    chk("t3_tc_a", tc1, 0);
    cyc();
    chk("t3_q_b", q1, 9);
    chk("t3_tc_b", tc1, 1);
    cyc();
    chk("t3_q_c", q1, 9);
    chk("t3_tc_c", tc1, 1);

    // Saturate and wrap at the bottom from reset
    do_reset();
    en = 1'b1; up = DIR_DOWN;
    cyc();
    chk("lo_sat_q", q1, 0);
    chk("lo_sat_tc", tc1, 1);
    chk("lo_wrap_q", q0, 9);
    chk("lo_wrap_tc", tc0, 1);

    // Test 4: prescaler period and en freeze
    do_reset();
    en = 1'b1; up = DIR_UP;
    cyc(); chk("t4_e1", q2, 0);
    cyc(); chk("t4_e2", q2, 0);
    cyc(); chk("t4_e3", q2, 1);
    cyc(); chk("t4_e4", q2, 1);
    en = 1'b0;
    cyc(); chk("t4_e5", q2, 1);
    cyc(); chk("t4_e6", q2, 1);
    en = 1'b1;
    cyc(); chk("t4_e7", q2, 1);
    cyc(); chk("t4_e8", q2, 2);

    // Test 5: over-range load coincident with a tick clamps and suppresses the step
    do_reset();
    en = 1'b1; up = DIR_UP;
    load = 1'b1; load_val = 4'd15;
    cyc();
    chk("t5_q", q0, 9);
    chk("t5_tc", tc0, 0);
    chk("t5_pre_q", q2, 9);
    load = 1'b0;
    cyc();
    chk("t5_wrap_q", q0, 0);
    chk("t5_wrap_tc", tc0, 1);

    // Test 6: asynchronous reset mid-cycle
    do_reset();
    en = 1'b1; up = DIR_UP;
    repeat (5) cyc();
    chk("t6_pre_q", q0, 5);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_q", q0, 0);
    chk("t6_async_tc", tc0, 0);
    cyc();
    chk("t6_hold_q", q0, 0);
    rst = 1'b0;
    cyc();
    chk("t6_resume_q", q0, 1);
    cyc();
    chk("t6_resume_q2", q0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
